nn_stream_classifier: RTL

NN_STREAM_CLASSIFIER -- requirements
Module: nn_stream_classifier

---
 rtl/nn_stream_classifier.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/nn_stream_classifier.sv
// Streaming linear classifier: collects N_IN samples, scores N_CLASS classes with one signed MAC
// per cycle, reports the arg-max class. Define NN_BIAS_EN to add per-class bias registers.
module nn_stream_classifier #(
  parameter  int DATA_W  = 16,
  parameter  int N_IN    = 4,
  parameter  int N_CLASS = 4,
  parameter  int W_W     = 8,
  localparam int ADDR_W  = $clog2(N_CLASS*N_IN + N_CLASS),
  localparam int CAT_W   = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              input_signal,
  input  logic [DATA_W-1:0] in,
  input  logic              w_we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [W_W-1:0]    w_data,
  output logic [CAT_W-1:0]  category,
  output logic              category_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int N_W = N_CLASS * N_IN;
`ifdef NN_BIAS_EN
  localparam int N_MEM = N_W + N_CLASS;
`else
  localparam int N_MEM = N_W;
`endif
  localparam int MI_W  = (N_MEM > 1) ? $clog2(N_MEM) : 1;
  localparam int K_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int P_W   = DATA_W + W_W;
  localparam int ACC_W = DATA_W + W_W + $clog2(N_IN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_e;
  state_e state_q, state_d;

  logic                     strobe_prev_q, busy_q, pend_q, valid_q, overrun_q;
  logic [K_W-1:0]           cnt_q, k_q;
  logic [CAT_W-1:0]         cls_q, score_cls_q, best_cls_q, cat_q;
  logic                     score_vld_q;
  logic signed [DATA_W-1:0] samp_q [N_IN];
  logic signed [W_W-1:0]    wmem_q [N_MEM];
  logic signed [ACC_W-1:0]  acc_q, acc_d, score_q, best_q, init_acc;

  logic                     rise, accept, frame_end, class_end, last_mac;
  logic [MI_W-1:0]          w_idx;
  logic signed [P_W-1:0]    a_ext, b_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext;
`ifdef NN_BIAS_EN
  logic [CAT_W-1:0]         bias_sel;
  logic [MI_W-1:0]          b_idx;
`endif

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned
  // and infer a latch.
  always_comb begin
    rise      = input_signal & ~strobe_prev_q;
    accept    = rise & ~busy_q;
    frame_end = accept && (cnt_q == K_W'(N_IN-1)) && (state_q == S_IDLE);
    class_end = (k_q == K_W'(N_IN-1));
    last_mac  = class_end && (cls_q == CAT_W'(N_CLASS-1));
    w_idx     = MI_W'(int'(cls_q) * N_IN + int'(k_q));
    a_ext     = {{W_W{samp_q[k_q][DATA_W-1]}}, samp_q[k_q]};
    b_ext     = {{DATA_W{wmem_q[w_idx][W_W-1]}}, wmem_q[w_idx]};
    prod      = a_ext * b_ext;
    prod_ext  = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    acc_d     = acc_q + prod_ext;
    init_acc  = '0;
`ifdef NN_BIAS_EN
    // Bias of the class about to start: class 0 on frame start, else the next class.
    bias_sel  = (frame_end || last_mac) ? '0 : cls_q + 1'b1;
    b_idx     = MI_W'(N_W + int'(bias_sel));
    init_acc  = {{(ACC_W-W_W){wmem_q[b_idx][W_W-1]}}, wmem_q[b_idx]};
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (frame_end) state_d = S_MAC;
      S_MAC:   if (last_mac) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: weights and the sample buffer are cleared by reset, so they are built from resettable
  // flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      strobe_prev_q <= 1'b0;
      busy_q        <= 1'b0;
      pend_q        <= 1'b0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      cnt_q         <= '0;
      k_q           <= '0;
      cls_q         <= '0;
      score_cls_q   <= '0;
      best_cls_q    <= '0;
      cat_q         <= '0;
      score_vld_q   <= 1'b0;
      acc_q         <= '0;
      score_q       <= '0;
      best_q        <= '0;
      for (int i = 0; i < N_IN; i++)  samp_q[i] <= '0;
      for (int i = 0; i < N_MEM; i++) wmem_q[i] <= '0;
    end else begin
      strobe_prev_q <= input_signal;
      if (rise && busy_q) overrun_q <= 1'b1;

      if (accept) begin
        samp_q[cnt_q] <= in;
        cnt_q         <= (cnt_q == K_W'(N_IN-1)) ? '0 : cnt_q + 1'b1;
      end

      if (w_we && !busy_q && (int'(w_addr) < N_MEM))
        wmem_q[MI_W'(w_addr)] <= w_data;

      if (state_q == S_MAC) begin
        acc_q       <= class_end ? init_acc : acc_d;
        k_q         <= class_end ? '0 : k_q + 1'b1;
        if (class_end) cls_q <= last_mac ? '0 : cls_q + 1'b1;
        score_vld_q <= class_end;
        score_q     <= acc_d;
        score_cls_q <= cls_q;
      end else begin
        score_vld_q <= 1'b0;
        if (frame_end) begin
          acc_q <= init_acc;
          k_q   <= '0;
          cls_q <= '0;
        end
      end

      // Strict greater-than keeps the lower index on ties.
      if (score_vld_q && ((score_cls_q == '0) || (score_q > best_q))) begin
        best_q     <= score_q;
        best_cls_q <= score_cls_q;
      end

      pend_q  <= (state_q == S_DONE);
      valid_q <= pend_q;
      if (pend_q) cat_q <= best_cls_q;
      busy_q  <= (state_q != S_IDLE) || pend_q;
    end
  end

  assign category       = cat_q;
  assign category_valid = valid_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule
